// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy opponent controller.
//   enemy_state_e : behaviour states (move, windup, stunned, dead)
//   LANE_MIN      : lowest lane number; lanes run LANE_MIN..NUM_POS
package enemy_pkg;

    typedef enum logic [1:0] {
        StMove   = 2'd0,
        StWindup = 2'd1,
        StStun   = 2'd2,
        StDead   = 2'd3
    } enemy_state_e;

    localparam int unsigned LANE_MIN = 1;

endpackage

// File: rtl/enemy_tick_gen.sv
// Enabled period counter. Counts enabled cycles from 0 and pulses tick on the
// cycle the count reaches period-1, then wraps to 0.
//   clock, reset_n : clock, synchronous active-low reset
//   enable         : count advances only when high; tick is gated by it
//   clear          : restart the count from 0 on the next enabled edge
//   period         : cycles per tick (CNT_W+1 bits so the full period fits)
//   tick           : one-cycle pulse on the last cycle of each period
module enemy_tick_gen #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W:0]   period,
    output logic             tick
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_last;

    assign at_last = ({1'b0, count_q} == (period - (CNT_W + 1)'(1)));
    assign tick    = enable & at_last;

    always_comb begin
        count_d = count_q;
        if (enable) begin
            if (clear || at_last) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/enemy_ai.sv
// Opponent behaviour controller: walks the enemy across lanes on a move timer,
// winds up and throws an attack every few moves, is stunned by player hits,
// goes permanently aggressive at low health and latches dead at zero health.
//   clock, reset_n : clock, synchronous active-low reset (overrides enable)
//   enable         : when low all state holds and pulses are suppressed
//   go             : move direction, 1 = lane+1, 0 = lane-1
//   health         : current enemy health
//   hit            : one-cycle pulse, player punch landed
//   x_pos          : current lane 1..NUM_POS
//   aggressive     : sticky aggressive-mode flag
//   attack         : one-cycle attack pulse
//   stunned, dead  : state flags
//   write_en       : one-cycle redraw request
module enemy_ai
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_POS     = 3,
    parameter int unsigned POS_W       = 2,
    parameter int unsigned HEALTH_W    = 4,
    parameter int unsigned AGGR_THRESH = 6,
    parameter int unsigned CALM_TICKS  = 25000000,
    parameter int unsigned AGGR_TICKS  = 12500000,
    parameter int unsigned STUN_TICKS  = 25000000,
    parameter int unsigned CALM_MOVES  = 4,
    parameter int unsigned AGGR_MOVES  = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                go,
    input  logic [HEALTH_W-1:0] health,
    input  logic                hit,
    output logic [POS_W-1:0]    x_pos,
    output logic                aggressive,
    output logic                attack,
    output logic                stunned,
    output logic                dead,
    output logic                write_en
);

    localparam int unsigned CNT_W     = (CALM_TICKS > 1) ? $clog2(CALM_TICKS) : 1;
    localparam int unsigned MOVES_MAX = (CALM_MOVES > AGGR_MOVES) ? CALM_MOVES : AGGR_MOVES;
    localparam int unsigned MCNT_W    = (MOVES_MAX > 1) ? $clog2(MOVES_MAX) : 1;

    localparam logic [CNT_W:0]    CALM_PER  = (CNT_W + 1)'(CALM_TICKS);
    localparam logic [CNT_W:0]    AGGR_PER  = (CNT_W + 1)'(AGGR_TICKS);
    localparam logic [CNT_W:0]    STUN_PER  = (CNT_W + 1)'(STUN_TICKS);
    localparam logic [MCNT_W-1:0] CALM_LAST = MCNT_W'(CALM_MOVES - 1);
    localparam logic [MCNT_W-1:0] AGGR_LAST = MCNT_W'(AGGR_MOVES - 1);
    localparam logic [POS_W:0]    LANE_LO   = (POS_W + 1)'(LANE_MIN);
    localparam logic [POS_W:0]    LANE_HI   = (POS_W + 1)'(NUM_POS);
    localparam logic [POS_W:0]    LANE_OVER = (POS_W + 1)'(NUM_POS + 1);

    enemy_state_e      state_q, state_d;
    logic [POS_W-1:0]  x_pos_q, x_pos_d;
    logic [MCNT_W-1:0] move_cnt_q, move_cnt_d;
    logic              aggr_q, aggr_d;
    logic              attack_q, attack_d;
    logic              write_en_q, write_en_d;

    logic              tick;
    logic              clear;
    logic [CNT_W:0]    period;
    logic [MCNT_W-1:0] move_last;
    logic [POS_W:0]    lane_ext, lane_step, lane_wrap;
    logic              low_health;

    assign low_health = (health != '0) && (32'(health) < AGGR_THRESH);
    assign move_last  = aggr_q ? AGGR_LAST : CALM_LAST;

    always_comb begin
        period = aggr_q ? AGGR_PER : CALM_PER;
        if (state_q == StStun) begin
            period = STUN_PER;
        end
    end

    // Lane arithmetic one bit wider than x_pos so both wrap cases are visible.
    always_comb begin
        lane_ext  = {1'b0, x_pos_q};
        lane_step = go ? (lane_ext + (POS_W + 1)'(1)) : (lane_ext - (POS_W + 1)'(1));
        lane_wrap = lane_step;
        if (lane_step == LANE_OVER) begin
            lane_wrap = LANE_LO;
        end else if (lane_step == '0) begin
            lane_wrap = LANE_HI;
        end
    end

    // Events are checked in priority order: death, hit, mode switch, tick.
    always_comb begin
        state_d    = state_q;
        x_pos_d    = x_pos_q;
        move_cnt_d = move_cnt_q;
        aggr_d     = aggr_q;
        attack_d   = 1'b0;
        write_en_d = 1'b0;
        clear      = 1'b0;
        if (enable && state_q != StDead) begin
            if (health == '0) begin
                state_d    = StDead;
                write_en_d = 1'b1;
                clear      = 1'b1;
            end else if (hit && (state_q == StMove || state_q == StWindup)) begin
                state_d    = StStun;
                move_cnt_d = '0;
                write_en_d = 1'b1;
                clear      = 1'b1;
            end else if (low_health && !aggr_q) begin
                aggr_d     = 1'b1;
                move_cnt_d = '0;
                write_en_d = 1'b1;
                clear      = 1'b1;
            end else if (tick) begin
                write_en_d = 1'b1;
                clear      = 1'b1;
                unique case (state_q)
                    StMove: begin
                        if (move_cnt_q == move_last) begin
                            state_d    = StWindup;
                            move_cnt_d = '0;
                        end else begin
                            x_pos_d    = POS_W'(lane_wrap);
                            move_cnt_d = move_cnt_q + 1'b1;
                        end
                    end
                    StWindup: begin
                        attack_d = 1'b1;
                        state_d  = StMove;
                    end
                    StStun: begin
                        state_d = StMove;
                    end
                    default: begin
                        write_en_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StMove;
            x_pos_q    <= POS_W'(LANE_MIN);
            move_cnt_q <= '0;
            aggr_q     <= 1'b0;
            attack_q   <= 1'b0;
            write_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_pos_q    <= x_pos_d;
            move_cnt_q <= move_cnt_d;
            aggr_q     <= aggr_d;
            attack_q   <= attack_d;
            write_en_q <= write_en_d;
        end
    end

    enemy_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (clear),
        .period  (period),
        .tick    (tick)
    );

    assign x_pos      = x_pos_q;
    assign aggressive = aggr_q;
    assign attack     = attack_q;
    assign write_en   = write_en_q;
    assign stunned    = (state_q == StStun);
    assign dead       = (state_q == StDead);

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai with short timer periods and hand-computed
// expectations. Edge k means the k-th rising edge after reset release.
module tb_enemy_ai;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       go;
    logic [3:0] health;
    logic       hit;
    logic [1:0] x_pos;
    logic       aggressive;
    logic       attack;
    logic       stunned;
    logic       dead;
    logic       write_en;

    int n_vec;
    int n_err;
    int wr_cnt;
    int atk_cnt;

    enemy_ai #(
        .NUM_POS     (3),
        .POS_W       (2),
        .HEALTH_W    (4),
        .AGGR_THRESH (6),
        .CALM_TICKS  (8),
        .AGGR_TICKS  (4),
        .STUN_TICKS  (6),
        .CALM_MOVES  (4),
        .AGGR_MOVES  (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .go         (go),
        .health     (health),
        .hit        (hit),
        .x_pos      (x_pos),
        .aggressive (aggressive),
        .attack     (attack),
        .stunned    (stunned),
        .dead       (dead),
        .write_en   (write_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each and counting pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (write_en) wr_cnt++;
            if (attack) atk_cnt++;
        end
    endtask

    task automatic do_reset(input logic dir);
        reset_n = 1'b0;
        enable  = 1'b1;
        hit     = 1'b0;
        health  = 4'd15;
        go      = dir;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wr_cnt  = 0;
        atk_cnt = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // 1: calm walk, windup, attack
        do_reset(1'b1);
        check_eq("rst_x", int'(x_pos), 1);
        check_eq("rst_aggr", int'(aggressive), 0);
        check_eq("rst_flags", int'({attack, stunned, dead, write_en}), 0);
        run(7);  check_eq("t1_x_e7", int'(x_pos), 1);
        run(1);  check_eq("t1_x_e8", int'(x_pos), 2);
                 check_eq("t1_wr_e8", int'(write_en), 1);
        run(8);  check_eq("t1_x_e16", int'(x_pos), 3);
        run(8);  check_eq("t1_x_e24", int'(x_pos), 1);
        run(8);  check_eq("t1_windup_x", int'(x_pos), 1);
                 check_eq("t1_windup_wr", int'(write_en), 1);
                 check_eq("t1_windup_atk", int'(attack), 0);
        run(8);  check_eq("t1_attack", int'(attack), 1);
        run(1);  check_eq("t1_attack_pulse", int'(attack), 0);
        run(7);  check_eq("t1_x_e48", int'(x_pos), 2);
        check_eq("t1_wr_count", wr_cnt, 6);
        check_eq("t1_atk_count", atk_cnt, 1);

        // 2: walking down wraps to the top lane
        do_reset(1'b0);
        run(8);  check_eq("t2_x_e8", int'(x_pos), 3);
        run(8);  check_eq("t2_x_e16", int'(x_pos), 2);

        // 3: aggressive switch and faster cadence
        do_reset(1'b1);
        run(10); check_eq("t3_x_e10", int'(x_pos), 2);
        health = 4'd5;
        run(1);  check_eq("t3_aggr", int'(aggressive), 1);
                 check_eq("t3_aggr_wr", int'(write_en), 1);
        run(3);  check_eq("t3_x_hold", int'(x_pos), 2);
        run(1);  check_eq("t3_x_move", int'(x_pos), 3);
        run(4);  check_eq("t3_windup_wr", int'(write_en), 1);
                 check_eq("t3_windup_x", int'(x_pos), 3);
        run(4);  check_eq("t3_attack", int'(attack), 1);
        health = 4'd15;
        run(4);  check_eq("t3_aggr_sticky", int'(aggressive), 1);
                 check_eq("t3_x_wrap", int'(x_pos), 1);

        // 4: hit during windup cancels the attack; hit while stunned ignored
        do_reset(1'b1);
        run(32); check_eq("t4_pre_stun", int'(stunned), 0);
        run(3);
        hit = 1'b1;
        run(1);  hit = 1'b0;
        check_eq("t4_stunned", int'(stunned), 1);
        check_eq("t4_stun_wr", int'(write_en), 1);
        wr_cnt  = 0;
        atk_cnt = 0;
        run(2);
        hit = 1'b1;
        run(1);  hit = 1'b0;
        run(2);  check_eq("t4_still_stun", int'(stunned), 1);
                 check_eq("t4_no_wr", wr_cnt, 0);
        run(1);  check_eq("t4_unstun", int'(stunned), 0);
                 check_eq("t4_unstun_wr", int'(write_en), 1);
        run(7);  check_eq("t4_x_hold", int'(x_pos), 1);
        run(1);  check_eq("t4_x_move", int'(x_pos), 2);
        check_eq("t4_no_attack", atk_cnt, 0);

        // 5: death beats hit, then reset (with enable low) revives
        do_reset(1'b1);
        run(9);
        health = 4'd0;
        hit    = 1'b1;
        run(1);  hit = 1'b0;
        check_eq("t5_dead", int'(dead), 1);
        check_eq("t5_not_stun", int'(stunned), 0);
        check_eq("t5_dead_wr", int'(write_en), 1);
        wr_cnt  = 0;
        atk_cnt = 0;
        run(30); check_eq("t5_x_frozen", int'(x_pos), 2);
                 check_eq("t5_quiet", wr_cnt + atk_cnt, 0);
                 check_eq("t5_still_dead", int'(dead), 1);
        health  = 4'd15;
        enable  = 1'b0;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        check_eq("t5_rst_x", int'(x_pos), 1);
        check_eq("t5_rst_dead", int'(dead), 0);

        // 6: enable low freezes everything, including hit
        do_reset(1'b1);
        run(5);
        enable = 1'b0;
        run(5);
        hit = 1'b1;
        run(1);  hit = 1'b0;
        run(14); check_eq("t6_x_frozen", int'(x_pos), 1);
                 check_eq("t6_no_stun", int'(stunned), 0);
                 check_eq("t6_no_pulse", wr_cnt + atk_cnt, 0);
        enable = 1'b1;
        run(2);  check_eq("t6_x_hold", int'(x_pos), 1);
        run(1);  check_eq("t6_x_move", int'(x_pos), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enemy_ai.md
Name: enemy_ai

Overview:
Parametrised opponent behaviour controller for the boxing game. It steps the enemy across NUM_POS lanes on an internal move timer, winds up and throws attacks after a configurable number of moves, and enters a stun state when the player lands a punch. It switches permanently to a faster aggressive mode when health falls below a threshold, and latches a dead state at zero health. It sits between the health/hit logic and the VGA draw controller, which redraws on write_en.

Parameters:
NUM_POS, 3, number of lanes (>=2); x_pos encodes lanes 1..NUM_POS
POS_W, 2, x_pos width; must satisfy 2^POS_W > NUM_POS
HEALTH_W, 4, health input width
AGGR_THRESH, 6, aggressive when 0 < health < AGGR_THRESH
CALM_TICKS, 25000000, enabled cycles per move step in calm mode
AGGR_TICKS, 12500000, enabled cycles per move step in aggressive mode (<= CALM_TICKS)
STUN_TICKS, 25000000, enabled cycles spent stunned (<= CALM_TICKS)
CALM_MOVES, 4, move steps before a windup, calm mode (>=1)
AGGR_MOVES, 2, move steps before a windup, aggressive mode (>=1)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
enable  in  1  advance enable; when low, all state and counters hold
go  in  1  direction bit sampled at each move: 1 = lane+1, 0 = lane-1
health  in  HEALTH_W  current enemy health
hit  in  1  one-cycle pulse: player punch landed
x_pos  out  POS_W  current lane 1..NUM_POS
aggressive  out  1  sticky aggressive-mode flag
attack  out  1  one-cycle pulse: attack thrown
stunned  out  1  high while in STUN
dead  out  1  high while in DEAD
write_en  out  1  one-cycle redraw request

Behaviour:
- Reset (clock edge with reset_n=0, overrides enable): state=MOVE, x_pos=1, aggressive=0, attack=0, stunned=0, dead=0, write_en=0, tick counter=0, move_cnt=0.
- enable=0: no state change, counters frozen, attack and write_en forced 0.
- Tick counter: counts enabled cycles from 0. The tick fires on the cycle count==period-1, then count returns to 0. Period is AGGR_TICKS when aggressive, CALM_TICKS otherwise, and STUN_TICKS in STUN. The counter clears on every state entry and on the mode switch.
- States: MOVE, WINDUP, STUN, DEAD. All outputs are registered, so effects appear one cycle after the cause.
- MOVE, on tick:
  - If move_cnt == M-1 (M = AGGR_MOVES or CALM_MOVES): go to WINDUP, move_cnt=0, lane unchanged.
  - Otherwise: lane steps per go, move_cnt+1.
  - Wrap: NUM_POS+1 -> 1; 0 -> NUM_POS.
- WINDUP, on tick: attack=1 for one cycle, then return to MOVE.
- hit in MOVE or WINDUP: go to STUN, stunned=1, move_cnt=0. A hit in WINDUP cancels the pending attack. A hit while in STUN is ignored and does not extend the stun.
- STUN, on tick: return to MOVE, stunned=0.
- Mode switch: when 0 < health < AGGR_THRESH and aggressive=0, set aggressive=1 (sticky until reset), clear the tick counter and move_cnt, and keep the current state.
- health==0 in any state: enter DEAD. dead=1, stunned=0, x_pos held. DEAD is exited only by reset.
- Priority within one cycle: reset > health==0 > hit > mode switch > tick.
- write_en is a one-cycle pulse on each of: lane change, WINDUP entry, attack, STUN entry, STUN exit, mode switch, DEAD entry. At most one pulse per cycle; coincident events produce a single pulse.
- Width rule: the counter is $clog2(CALM_TICKS) bits wide. Lane arithmetic is done at POS_W+1 bits before wrapping.

Decomposition:
- Shared package enemy_pkg: state enum (MOVE, WINDUP, STUN, DEAD), lane constant LANE_MIN=1.
- Sub-module enemy_tick_gen: parametrised enabled counter. Inputs: clear, period; output: tick pulse.

Test Plan (NUM_POS=3, CALM_TICKS=8, AGGR_TICKS=4, STUN_TICKS=6, CALM_MOVES=4, AGGR_MOVES=2, enable=1):
1. Reset, health=15, go=1 -> x_pos 1->2->3->1 at enabled cycles 8/16/24; WINDUP entered at 32 with x_pos=1; attack pulse at 40; x_pos=2 at 48; write_en pulses at each of these.
2. go=0 from reset -> x_pos 1->3 at cycle 8, 3->2 at cycle 16 (wrap low).
3. Health set to 5 at cycle 10 -> aggressive=1 and write_en on the next cycle. Then ticks every 4 cycles: one lane move, then WINDUP, then attack at the third tick. Health then raised to 15 -> aggressive stays 1.
4. hit during WINDUP -> stunned=1 next cycle, no attack pulse, stunned=0 after 6 enabled cycles, then the first move one tick later.
5. health=0 in the same cycle as hit -> dead=1, stunned=0, x_pos frozen, no later write_en or attack. reset_n=0 -> x_pos=1, dead=0.
6. enable=0 for 20 cycles at count=5 -> all outputs frozen, no pulses. After re-enable, the move occurs 3 cycles later.
